// File: rtl/fan_sample_sched_pkg.sv
// Shared state encoding for the FanCTRL sample sequencer and its neighbours.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package fan_sample_sched_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT    = 2'd1;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 2'd2;
  localparam logic [STATE_W-1:0] ST_STROBE  = 2'd3;

  // A sample is in flight from the capture cycle up to and including its strobe
  function automatic logic state_is_busy(input logic [STATE_W-1:0] st);
    return (st == ST_CAPTURE) || (st == ST_STROBE);
  endfunction

endpackage

// File: rtl/fan_sample_sched_sync_edge.sv
// 2-FF synchronizer for an asynchronous pin with rising-edge detect.
// Latency: level follows the pin after 2 clocks; rise pulses in the first cycle the level is high.
// Backpressure: none, free-running; one single-cycle pulse per synchronised rising edge.
module fan_sample_sched_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Two flops resolve metastability, the third holds last cycle's level for edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_sync_d;

endmodule

// File: rtl/fan_sample_sched.sv
// Sample sequencer ahead of FanCTRL: clk_en tick, dataVaild strobe, held ADC/SET samples, overrun flag.
// Latency: auto strobe every TICKS_PER_SAMPLE*PRESCALE clocks; ext edge to strobe 3 clocks + up to PRESCALE.
// Backpressure: none; an ext request arriving while a sample is in flight is dropped and flagged.
module fan_sample_sched
  import fan_sample_sched_pkg::*;
#(
  parameter int ADC_BITWIDTH     = 4,
  parameter int PRESCALE         = 10,
  parameter int TICKS_PER_SAMPLE = 10000
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    ena_i,
  input  logic                    mode_auto_i,
  input  logic                    ext_strb_i,
  input  logic                    config_en_i,
  input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic [ADC_BITWIDTH-1:0] SET_value_i,
  output logic                    clk_en_o,
  output logic                    dataVaild_STRB_o,
  output logic [ADC_BITWIDTH-1:0] ADC_value_o,
  output logic [ADC_BITWIDTH-1:0] SET_value_o,
  output logic                    config_en_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [STATE_W-1:0]      state_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = $clog2(TICKS_PER_SAMPLE);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SAMPLE - 1);

  logic [PW-1:0]           r_pre;
  logic [TW-1:0]           r_tick;
  logic [STATE_W-1:0]      r_state;
  logic                    r_mode_d;
  logic                    r_overrun;
  logic [ADC_BITWIDTH-1:0] r_adc;
  logic [ADC_BITWIDTH-1:0] r_set;

  logic [TW-1:0]           w_tick_inc;
  logic [TW-1:0]           w_tick_nxt;
  logic [STATE_W-1:0]      w_state_nxt;
  logic                    w_clk_en;
  logic                    w_cfg;
  logic                    w_cfg_rise;
  logic                    w_ext_lvl;
  logic                    w_ext_rise;
  logic                    w_hold_off;
  logic                    w_busy;
  logic                    w_capture;
  logic                    w_strobe;
  logic                    w_unused;

  fan_sample_sched_sync_edge u_cfg_sync (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_async (config_en_i),
    .o_level (w_cfg),
    .o_rise  (w_cfg_rise)
  );

  fan_sample_sched_sync_edge u_ext_sync (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_async (ext_strb_i),
    .o_level (w_ext_lvl),
    .o_rise  (w_ext_rise)
  );

  // Config acts on its level and the ext pin on its edge; the other halves are not needed
  assign w_unused = &{1'b0, w_cfg_rise, w_ext_lvl};

  // Config or disable overrides every state and suppresses any strobe due this cycle
  assign w_hold_off = ~ena_i | w_cfg;
  assign w_clk_en   = (r_pre == PRE_LAST);
  assign w_busy     = state_is_busy(r_state);
  assign w_capture  = (r_state == ST_CAPTURE) & ~w_hold_off;
  assign w_tick_inc = r_tick + 1'b1;

  // Free-running prescaler, independent of enable and FSM state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_clk_en ? '0 : r_pre + 1'b1;
    end
  end

  // Next-state, tick count and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_strobe    = 1'b0;
    if (w_hold_off) begin
      w_state_nxt = ST_IDLE;
      w_tick_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_tick_nxt  = '0;
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (mode_auto_i != r_mode_d) begin
            // Source switched mid-wait: restart the interval from scratch
            w_tick_nxt = '0;
          end else if (mode_auto_i) begin
            // The tick that brings the count to its last value starts the capture,
            // so the strobe lands on the following tick: one full period per sample
            if (w_clk_en) begin
              w_tick_nxt = w_tick_inc;
              if (w_tick_inc == TICK_LAST) begin
                w_state_nxt = ST_CAPTURE;
              end
            end
          end else begin
            w_tick_nxt = '0;
            if (w_ext_rise) begin
              w_state_nxt = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          w_state_nxt = ST_STROBE;
        end
        ST_STROBE: begin
          if (w_clk_en) begin
            w_strobe    = 1'b1;
            w_tick_nxt  = '0;
            w_state_nxt = ST_WAIT;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
        end
      endcase
    end
  end

  // FSM state, tick count and last-seen mode for change detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ST_IDLE;
      r_tick   <= '0;
      r_mode_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_mode_d <= mode_auto_i;
    end
  end

  // Sample holding: ADC only on capture; SET also follows the pins while configuring
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_adc <= '0;
      r_set <= '0;
    end else begin
      if (w_capture) begin
        r_adc <= ADC_value_i;
      end
      if (w_capture || w_cfg) begin
        r_set <= SET_value_i;
      end
    end
  end

  // Sticky overrun: an ext request while a sample is in flight; config clears it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_overrun <= 1'b0;
    end else if (w_cfg) begin
      r_overrun <= 1'b0;
    end else if (w_ext_rise && !mode_auto_i && w_busy) begin
      r_overrun <= 1'b1;
    end
  end

  assign clk_en_o         = w_clk_en;
  assign dataVaild_STRB_o = w_strobe;
  assign ADC_value_o      = r_adc;
  assign SET_value_o      = r_set;
  assign config_en_o      = w_cfg;
  assign busy_o           = w_busy;
  assign overrun_o        = r_overrun;
  assign state_o          = r_state;

endmodule

// File: tb/tb_fan_sample_sched.sv
// Scoreboard bench for fan_sample_sched: expected strobes are queued by the stimulus and
// popped by an independent monitor; the clk_en tick is checked every cycle.
module tb_fan_sample_sched;

  localparam int P = 4;
  localparam int T = 5;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ena = 1'b1;
  logic         mode = 1'b1;
  logic         ext = 1'b0;
  logic         cfg = 1'b0;
  logic [W-1:0] adc_in = '0;
  logic [W-1:0] set_in = '0;

  logic         clk_en_o;
  logic         strb_o;
  logic [W-1:0] adc_o;
  logic [W-1:0] set_o;
  logic         cfg_o;
  logic         busy_o;
  logic         ovr_o;
  logic [1:0]   state_o;

  fan_sample_sched #(
    .ADC_BITWIDTH     (W),
    .PRESCALE         (P),
    .TICKS_PER_SAMPLE (T)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .ena_i            (ena),
    .mode_auto_i      (mode),
    .ext_strb_i       (ext),
    .config_en_i      (cfg),
    .ADC_value_i      (adc_in),
    .SET_value_i      (set_in),
    .clk_en_o         (clk_en_o),
    .dataVaild_STRB_o (strb_o),
    .ADC_value_o      (adc_o),
    .SET_value_o      (set_o),
    .config_en_o      (cfg_o),
    .busy_o           (busy_o),
    .overrun_o        (ovr_o),
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; equals the prescaler phase mod P
  int cyc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int           at;
    logic [W-1:0] adc;
    logic [W-1:0] set;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] held_adc = '0;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timing, straight from the block's rules
  function automatic int first_clken(input int w);
    return w + (P - 1 - (w % P));
  endfunction

  // Auto mode: strobe on the T-th tick counted while waiting
  function automatic int auto_strobe(input int wait_entry);
    return first_clken(wait_entry) + (T - 1) * P;
  endfunction

  // Ext mode: pin high in cycle c -> synced edge in c+2, CAPTURE c+3, STROBE from c+4
  function automatic int ext_strobe(input int c);
    return first_clken(c + 4);
  endfunction

  task automatic expect_strobe(input int at, input logic [W-1:0] a, input logic [W-1:0] s);
    exp_t e;
    e.at = at;
    e.adc = a;
    e.set = s;
    q.push_back(e);
    held_adc = a;
  endtask

  task automatic drained(input string name);
    check(name, q.size(), 0);
    q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      step();
      guard++;
    end
    if (cyc < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_to: stuck at cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  // Monitor: clk_en cadence every cycle, strobes against the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("clk_en", clk_en_o, (cyc % P) == (P - 1));
        if (strb_o) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL strobe_unexpected: strobe at cycle %0d, none expected", cyc);
          end else begin
            e = q.pop_front();
            check("strobe_cycle", cyc, e.at);
            check("strobe_adc", adc_o, e.adc);
            check("strobe_set", set_o, e.set);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, n, s, b, e, w;
    logic [W-1:0] a_r, s_r;

    // Reset state
    adc_in = 4'h9;
    set_in = 4'h5;
    #23;
    check("reset_outputs", {clk_en_o, strb_o, adc_o, set_o, cfg_o, busy_o, ovr_o, state_o}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Auto mode: WAIT entered on edge 1; ADC 0x9 captured, then held while the pins read 0x2
    s = auto_strobe(1);
    expect_strobe(s, 4'h9, 4'h5);
    run_to(s + 1);
    adc_in = 4'h2;
    run_to(s + 6);
    check("adc_hold", adc_o, 4'h9);
    s = s + T * P;
    expect_strobe(s, 4'h2, 4'h5);
    for (int k = 0; k < 2; k++) begin
      run_to(s + 1);
      adc_in = rnd();
      set_in = rnd();
      s = s + T * P;
      expect_strobe(s, adc_in, set_in);
    end
    run_to(s + 1);
    drained("auto_missing");

    // Ext mode: single edge, busy through capture and strobe
    mode = 1'b0;
    run_to(cyc + 3);
    c = cyc;
    adc_in = rnd();
    set_in = rnd();
    ext = 1'b1;
    n = ext_strobe(c);
    expect_strobe(n, adc_in, set_in);
    step();
    ext = 1'b0;
    run_to(c + 3);
    check("busy_capture", busy_o, 1);
    run_to(n);
    check("busy_strobe", busy_o, 1);
    run_to(n + 1);
    check("busy_after", busy_o, 0);
    drained("ext_missing");

    // Randomly spaced ext requests, each allowed to finish
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 4)) step();
      c = cyc;
      adc_in = rnd();
      set_in = rnd();
      ext = 1'b1;
      n = ext_strobe(c);
      expect_strobe(n, adc_in, set_in);
      step();
      ext = 1'b0;
      run_to(n + 1);
      check("busy_idle", busy_o, 0);
    end
    drained("ext_rand_missing");
    check("overrun_quiet", ovr_o, 0);

    // Second edge while busy: overrun, request dropped
    step();
    c = cyc;
    adc_in = rnd();
    set_in = rnd();
    ext = 1'b1;
    n = ext_strobe(c);
    expect_strobe(n, adc_in, set_in);
    step();
    ext = 1'b0;
    step();
    ext = 1'b1;
    step();
    ext = 1'b0;
    run_to(n + 2);
    check("overrun_set", ovr_o, 1);
    run_to(n + 2 + 3 * P);
    drained("overrun_one_strobe");

    // Config pulse clears overrun and forces IDLE; switch back to auto meanwhile
    b = cyc;
    cfg = 1'b1;
    mode = 1'b1;
    run_to(b + 3);
    check("cfg_sync", cfg_o, 1);
    check("overrun_cfg", ovr_o, 0);
    check("state_cfg", state_o, 0);
    run_to(b + 4);
    cfg = 1'b0;
    w = b + 4 + 3;
    e = first_clken(w) + (T - 2) * P;

    // Config reaches the core exactly on the timer-expiry tick: no capture, no strobe
    run_to(e - 2);
    cfg = 1'b1;
    run_to(e);
    set_in = 4'h3;
    step();
    check("state_expiry_cfg", state_o, 0);
    check("set_track_3", set_o, 4'h3);
    check("adc_held_cfg", adc_o, held_adc);
    set_in = 4'hC;
    step();
    check("set_track_c", set_o, 4'hC);
    run_to(e + 4);
    cfg = 1'b0;
    w = e + 4 + 3;
    s = auto_strobe(w);
    expect_strobe(s, adc_in, 4'hC);
    run_to(s + 1);
    drained("cfg_release_missing");

    // Reset asserted during STROBE: everything drops at once, no strobe
    s = s + T * P;
    run_to(s - 1);
    check("state_strobe", state_o, 3);
    #1;
    rstn = 1'b0;
    #1;
    check("reset_async", {clk_en_o, strb_o, adc_o, set_o, cfg_o, busy_o, ovr_o, state_o}, 0);
    @(negedge clk);
    @(negedge clk);
    a_r = rnd();
    s_r = rnd();
    adc_in = a_r;
    set_in = s_r;
    rstn = 1'b1;
    s = auto_strobe(1);
    expect_strobe(s, a_r, s_r);
    run_to(s + 1);
    adc_in = rnd();
    s = s + T * P;
    expect_strobe(s, adc_in, s_r);
    run_to(s + 1);
    drained("post_reset_missing");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
